ttfs_charge_engine: RTL and testbench

TTFS_CHARGE_ENGINE -- requirements
Module: ttfs_charge_engine

---
 rtl/ttfs_charge_engine.sv | 137 +++++++++++++
 tb/tb_ttfs_charge_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttfs_charge_engine.sv
// TTFS charge engine: N signed slope registers updated by grouped presynaptic
// events (accumulate or step mode) and read back by a charge query port.
module ttfs_charge_engine #(
    parameter int unsigned N     = 256,
    parameter int unsigned LANES = 4,
    parameter int unsigned WW    = 8,
    parameter int unsigned SW    = 16,
    localparam int unsigned G    = N / LANES,
    localparam int unsigned GW   = (G > 1) ? $clog2(G) : 1,
    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 mode_i,
    input  logic                 clear_i,
    output logic                 busy_o,
    input  logic                 ev_valid_i,
    output logic                 ev_ready_o,
    input  logic [GW-1:0]        ev_group_i,
    input  logic [LANES*WW-1:0]  ev_weights_i,
    input  logic                 q_valid_i,
    output logic                 q_ready_o,
    input  logic [IW-1:0]        q_idx_i,
    input  logic                 q_tref_i,
    output logic                 rsp_valid_o,
    output logic signed [SW-1:0] rsp_charge_o,
    output logic                 sat_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic signed [SW-1:0] SAT_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {1'b1, {(SW-1){1'b0}}};

    state_t                r_state;
    logic [GW-1:0]         r_clr_grp;
    logic signed [SW-1:0]  r_slope [N];
    logic                  r_rsp_valid;
    logic signed [SW-1:0]  r_rsp_charge;
    logic                  r_sat;

    logic                  w_idle;
    logic                  w_ev_fire;
    logic                  w_q_fire;
    logic                  w_q_zero;
    logic                  w_ovf_any;
    logic [IW-1:0]         w_ev_idx [LANES];
    logic signed [WW-1:0]  w_wt     [LANES];
    logic signed [SW:0]    w_sum    [LANES];
    logic                  w_ovf    [LANES];
    logic signed [SW-1:0]  w_ev_new [LANES];

    assign w_idle    = (r_state == ST_IDLE);
    assign w_ev_fire = ev_valid_i & w_idle;
    assign w_q_fire  = q_valid_i & w_idle;
    // Step mode consumes the slope on every read, refractory or not.
    assign w_q_zero  = q_tref_i | mode_i;

    assign busy_o       = (r_state == ST_CLEAR);
    assign ev_ready_o   = w_idle;
    assign q_ready_o    = w_idle;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_charge_o = r_rsp_charge;
    assign sat_o        = r_sat;

    always_comb begin
        w_ovf_any = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_ev_idx[k] = IW'(32'(ev_group_i) * LANES + k);
            w_wt[k]     = $signed(ev_weights_i[k*WW +: WW]);
            // One guard bit: overflow shows as disagreement of the top two bits.
            w_sum[k]    = (SW+1)'(r_slope[w_ev_idx[k]]) + (SW+1)'(w_wt[k]);
            w_ovf[k]    = (w_sum[k][SW] != w_sum[k][SW-1]);
            if (mode_i) begin
                w_ev_new[k] = SW'(w_wt[k]);
            end else if (w_ovf[k]) begin
                w_ev_new[k] = w_sum[k][SW] ? SAT_MIN : SAT_MAX;
            end else begin
                w_ev_new[k] = w_sum[k][SW-1:0];
            end
            w_ovf_any = w_ovf_any | (w_ovf[k] & ~mode_i);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state      <= ST_IDLE;
            r_clr_grp    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_charge <= '0;
            r_sat        <= 1'b0;
            for (int unsigned n = 0; n < N; n++) begin
                r_slope[n] <= '0;
            end
        end else begin
            r_rsp_valid <= w_q_fire;
            if (w_q_fire) begin
                r_rsp_charge <= r_slope[q_idx_i];
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_ev_fire) begin
                        for (int unsigned k = 0; k < LANES; k++) begin
                            r_slope[w_ev_idx[k]] <= w_ev_new[k];
                        end
                        if (w_ovf_any) begin
                            r_sat <= 1'b1;
                        end
                    end
                    // Written after the event lanes so a zeroing read wins on collision.
                    if (w_q_fire && w_q_zero) begin
                        r_slope[q_idx_i] <= '0;
                    end
                    if (clear_i) begin
                        r_state   <= ST_CLEAR;
                        r_clr_grp <= '0;
                        r_sat     <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    for (int unsigned k = 0; k < LANES; k++) begin
                        r_slope[IW'(32'(r_clr_grp) * LANES + k)] <= '0;
                    end
                    if (r_clr_grp == GW'(G - 1)) begin
                        r_state <= ST_IDLE;
                    end
                    r_clr_grp <= r_clr_grp + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ttfs_charge_engine.sv
// Self-checking bench for ttfs_charge_engine: directed vectors plus a random
// phase, with query responses checked against a queue of expected charges.
module tb_ttfs_charge_engine;

    localparam int N     = 256;
    localparam int LANES = 4;
    localparam int WW    = 8;
    localparam int SW    = 16;
    localparam int G     = N / LANES;

    logic              CLK          = 1'b0;
    logic              RSTN         = 1'b0;
    logic              mode_i       = 1'b0;
    logic              clear_i      = 1'b0;
    logic              ev_valid_i   = 1'b0;
    logic [5:0]        ev_group_i   = '0;
    logic [31:0]       ev_weights_i = '0;
    logic              q_valid_i    = 1'b0;
    logic [7:0]        q_idx_i      = '0;
    logic              q_tref_i     = 1'b0;
    logic              busy_o;
    logic              ev_ready_o;
    logic              q_ready_o;
    logic              rsp_valid_o;
    logic signed [15:0] rsp_charge_o;
    logic              sat_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int model [N];
    bit model_sat = 1'b0;

    always #5 CLK = ~CLK;

    ttfs_charge_engine #(
        .N     (N),
        .LANES (LANES),
        .WW    (WW),
        .SW    (SW)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .mode_i       (mode_i),
        .clear_i      (clear_i),
        .busy_o       (busy_o),
        .ev_valid_i   (ev_valid_i),
        .ev_ready_o   (ev_ready_o),
        .ev_group_i   (ev_group_i),
        .ev_weights_i (ev_weights_i),
        .q_valid_i    (q_valid_i),
        .q_ready_o    (q_ready_o),
        .q_idx_i      (q_idx_i),
        .q_tref_i     (q_tref_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_charge_o (rsp_charge_o),
        .sat_o        (sat_o)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    always @(negedge CLK) begin
        if (RSTN && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                check_val("rsp_spurious", 1, 0);
            end else begin
                check_val("rsp_charge", int'(rsp_charge_o), exp_q.pop_front());
            end
        end
    end

    // Drives one cycle of stimulus; called just after a rising edge.
    task automatic cyc(input bit evv, input int grp, input int w0, input int w1,
                       input int w2, input int w3, input bit qv, input int idx,
                       input bit tref, input bit mode, input bit use_model, input int qexp);
        int w [4];
        int s;
        int n;
        w = '{w0, w1, w2, w3};
        mode_i       = mode;
        ev_valid_i   = evv;
        ev_group_i   = 6'(grp);
        ev_weights_i = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
        q_valid_i    = qv;
        q_idx_i      = 8'(idx);
        q_tref_i     = tref;
        if (qv) exp_q.push_back(use_model ? model[idx] : qexp);
        if (evv) begin
            for (int k = 0; k < LANES; k++) begin
                n = grp * LANES + k;
                if (mode) begin
                    model[n] = w[k];
                end else begin
                    s = model[n] + w[k];
                    if (s > 32767 || s < -32768) model_sat = 1'b1;
                    model[n] = sat16(s);
                end
            end
        end
        if (qv && (tref || mode)) model[idx] = 0;
        @(posedge CLK); #1;
        ev_valid_i = 1'b0;
        q_valid_i  = 1'b0;
        q_tref_i   = 1'b0;
    endtask

    task automatic ev(input int grp, input int w0, input int w1, input int w2,
                      input int w3, input bit mode);
        cyc(1'b1, grp, w0, w1, w2, w3, 1'b0, 0, 1'b0, mode, 1'b0, 0);
    endtask

    task automatic qry(input int idx, input bit tref, input bit mode, input int exp);
        cyc(1'b0, 0, 0, 0, 0, 0, 1'b1, idx, tref, mode, 1'b0, exp);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge CLK);
        check_val("rsp_missing", exp_q.size(), 0);
        exp_q.delete();
        @(posedge CLK); #1;
    endtask

    task automatic model_zero();
        foreach (model[i]) model[i] = 0;
        model_sat = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ready_bad;
        int grp;
        int idx;
        model_zero();

        // Reset state
        #2;
        check_val("rst_busy", busy_o, 0);
        check_val("rst_ev_ready", ev_ready_o, 1);
        check_val("rst_q_ready", q_ready_o, 1);
        check_val("rst_rsp_valid", rsp_valid_o, 0);
        check_val("rst_rsp_charge", int'(rsp_charge_o), 0);
        check_val("rst_sat", sat_o, 0);
        @(posedge CLK); #1;
        RSTN = 1'b1;
        @(posedge CLK); #1;

        // Slope accumulation across four lanes
        ev(1, 5, -3, 127, -128, 1'b0);
        ev(1, 5, -3, 127, -128, 1'b0);
        qry(4, 1'b0, 1'b0, 10);
        qry(5, 1'b0, 1'b0, -6);
        qry(6, 1'b0, 1'b0, 254);
        qry(7, 1'b0, 1'b0, -256);
        drain();
        check_val("acc_sat", sat_o, 0);
        check_val("hold_valid", rsp_valid_o, 0);
        check_val("hold_charge", int'(rsp_charge_o), -256);

        // Event and refractory query colliding on one neuron
        ev(2, 3, 0, 0, 0, 1'b0);
        cyc(1'b1, 2, 7, 4, 0, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 3);
        qry(8, 1'b0, 1'b0, 0);
        qry(9, 1'b0, 1'b0, 4);
        drain();

        // Step mode overwrite and consume, then mode change keeps slopes
        ev(0, 0, 0, -9, 0, 1'b1);
        qry(2, 1'b0, 1'b1, -9);
        qry(2, 1'b0, 1'b1, 0);
        qry(5, 1'b0, 1'b1, -6);
        qry(5, 1'b0, 1'b0, 0);
        qry(4, 1'b0, 1'b0, 10);
        drain();

        // Positive saturation
        for (int i = 0; i < 300; i++) ev(0, 127, 0, 0, 0, 1'b0);
        qry(0, 1'b0, 1'b0, 32767);
        drain();
        check_val("sat_set", sat_o, 1);
        repeat (3) @(posedge CLK);
        #1;
        check_val("sat_sticky", sat_o, 1);

        // Clear sweep; inputs held active and a second clear pulse must be ignored
        clear_i = 1'b1;
        @(posedge CLK); #1;
        clear_i = 1'b0;
        model_zero();
        check_val("clr_sat", sat_o, 0);
        cnt = 0;
        ready_bad = 0;
        ev_valid_i   = 1'b1;
        ev_weights_i = 32'h11111111;
        q_valid_i    = 1'b1;
        q_tref_i     = 1'b1;
        while (busy_o && cnt < 200) begin
            if (ev_ready_o || q_ready_o) ready_bad++;
            clear_i = (cnt == 5);
            cnt++;
            @(posedge CLK); #1;
        end
        ev_valid_i = 1'b0;
        q_valid_i  = 1'b0;
        q_tref_i   = 1'b0;
        clear_i    = 1'b0;
        check_val("clr_busy_cycles", cnt, 64);
        check_val("clr_ready_low", ready_bad, 0);
        check_val("clr_ev_ready_after", ev_ready_o, 1);
        qry(0, 1'b0, 1'b0, 0);
        qry(4, 1'b0, 1'b0, 0);
        qry(6, 1'b0, 1'b0, 0);
        qry(9, 1'b0, 1'b0, 0);
        qry(255, 1'b0, 1'b0, 0);
        drain();

        // Random mix against the bench model
        for (int i = 0; i < 300; i++) begin
            grp = int'($urandom_range(0, G - 1));
            idx = ($urandom_range(0, 3) == 0) ? grp * LANES + int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, N - 1));
            cyc(1'($urandom_range(0, 1)), grp,
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                1'($urandom_range(0, 1)), idx, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), 1'b1, 0);
        end
        drain();
        check_val("rand_sat", sat_o, int'(model_sat));

        // Reset in the middle of a clear sweep
        ev(63, 50, 0, 0, 0, 1'b0);
        clear_i = 1'b1;
        @(posedge CLK); #1;
        clear_i = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        RSTN = 1'b0;
        #1;
        check_val("abort_busy", busy_o, 0);
        check_val("abort_sat", sat_o, 0);
        check_val("abort_rsp_valid", rsp_valid_o, 0);
        @(posedge CLK); #3;
        RSTN = 1'b1;
        @(posedge CLK); #1;
        model_zero();
        check_val("abort_ev_ready", ev_ready_o, 1);
        check_val("abort_q_ready", q_ready_o, 1);
        check_val("abort_busy_after", busy_o, 0);
        qry(252, 1'b0, 1'b0, 0);
        qry(4, 1'b0, 1'b0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
